// File: rtl/sram_controller.sv
// Bridges a 32-bit pipeline load/store port to a 16-bit asynchronous SRAM.
// Each access moves the low halfword, then the high halfword, two cycles each.
module sram_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO1  = 3'd1,
      S_LO2  = 3'd2,
      S_HI1  = 3'd3,
      S_HI2  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic        is_wr_q, is_wr_d;
   logic [16:0] idx_q, idx_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic [18:0] off_s;
   logic        active_s;
   logic        hi_s;
   logic        drive_s;
   logic [15:0] dq_out_s;
   logic        unused_s;

   // Data memory is mapped at byte 1024; only the word-index bits of the offset matter.
   assign off_s    = address[18:0] - 19'd1024;
   assign unused_s = ^{address[31:19], off_s[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         is_wr_q <= 1'b0;
         idx_q   <= 17'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      is_wr_d = is_wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (wr_en || rd_en) begin
               state_d = S_LO1;
               is_wr_d = wr_en;   // write wins when both are requested
               idx_d   = off_s[18:2];
               wdata_d = write_data;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LO1: state_d = S_LO2;
         S_LO2: begin
            state_d = S_HI1;
            if (!is_wr_q) begin
               rdata_d[15:0] = SRAM_DQ;
            end else begin
               rdata_d = rdata_q;
            end
         end
         S_HI1: state_d = S_HI2;
         S_HI2: begin
            state_d = S_DONE;
            if (!is_wr_q) begin
               rdata_d[31:16] = SRAM_DQ;
            end else begin
               rdata_d = rdata_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      active_s = (state_q == S_LO1) || (state_q == S_LO2) ||
                 (state_q == S_HI1) || (state_q == S_HI2);
      hi_s     = (state_q == S_HI1) || (state_q == S_HI2);
      drive_s  = active_s && is_wr_q;
      if (hi_s) begin
         dq_out_s = wdata_q[31:16];
      end else begin
         dq_out_s = wdata_q[15:0];
      end
      if (active_s) begin
         SRAM_ADDR = {idx_q, hi_s};
      end else begin
         SRAM_ADDR = 18'd0;
      end
      SRAM_WE_N = ~(active_s && is_wr_q);
      SRAM_OE_N = ~(active_s && !is_wr_q);
      SRAM_CE_N = 1'b0;
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
      if (state_q == S_DONE) begin
         ready = 1'b1;
      end else if (state_q == S_IDLE) begin
         ready = ~(rd_en | wr_en);
      end else begin
         ready = 1'b0;
      end
   end

   assign SRAM_DQ   = drive_s ? dq_out_s : 16'hzzzz;
   assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller against a word-level memory model.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] write_data = 32'd0;
   wire  [31:0] read_data;
   wire         ready;
   wire  [15:0] sram_dq;
   wire  [17:0] sram_addr;
   wire         we_n, oe_n, ce_n, ub_n, lb_n;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] mem [0:262143];
   logic [31:0] ref_words [int];
   int          written_q [$];
   logic [31:0] exp_rd = 32'd0;

   sram_controller dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .address(address), .write_data(write_data),
      .read_data(read_data), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
      .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
   );

   always #5 clk = ~clk;

   // Behavioural asynchronous SRAM: drives on OE_N, stores on WE_N.
   assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
   always @(posedge clk) begin
      if (!we_n && !ce_n) mem[sram_addr] <= sram_dq;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] idx_of(input logic [31:0] a);
      logic [31:0] t;
      t = ((a - 32'd1024) / 32'd4) % 32'd131072;
      return t[16:0];
   endfunction

   task automatic idle_chk();
      @(negedge clk);
      chk("idle_ready", {31'd0, ready}, 32'd1);
      chk("idle_addr", {14'd0, sram_addr}, 32'd0);
      chk("idle_we", {31'd0, we_n}, 32'd1);
      chk("idle_oe", {31'd0, oe_n}, 32'd1);
      chk("idle_ctl", {29'd0, ce_n, ub_n, lb_n}, 32'd0);
   endtask

   // Call just after a rising edge with the DUT in IDLE.
   task automatic do_txn(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input bit chg, input bit hold);
      bit          is_wr;
      logic [16:0] idx;
      logic [31:0] hw;
      is_wr = wr;
      idx   = idx_of(a);
      wr_en = wr; rd_en = rd; address = a; write_data = d;
      @(negedge clk);
      chk("req_ready", {31'd0, ready}, 32'd0);
      for (int p = 0; p < 4; p++) begin
         @(posedge clk); #1;
         if (chg && p == 0) begin
            address = 32'd2048; write_data = 32'd0; wr_en = 1'b0; rd_en = 1'b0;
         end
         @(negedge clk);
         chk("busy_ready", {31'd0, ready}, 32'd0);
         chk("busy_addr", {14'd0, sram_addr}, {15'd0, idx} * 32'd2 + ((p >= 2) ? 32'd1 : 32'd0));
         chk("busy_we", {31'd0, we_n}, is_wr ? 32'd0 : 32'd1);
         chk("busy_oe", {31'd0, oe_n}, is_wr ? 32'd1 : 32'd0);
         if (is_wr) begin
            hw = (p < 2) ? (d % 32'd65536) : (d / 32'd65536);
            chk("busy_dq", {16'd0, sram_dq}, hw);
         end
      end
      @(posedge clk);
      if (is_wr) begin
         if (!ref_words.exists(int'(idx))) written_q.push_back(int'(idx));
         ref_words[int'(idx)] = d;
      end else begin
         exp_rd = ref_words[int'(idx)];
      end
      @(negedge clk);
      chk("done_ready", {31'd0, ready}, 32'd1);
      chk("done_rdata", read_data, exp_rd);
      chk("done_addr", {14'd0, sram_addr}, 32'd0);
      chk("done_we", {31'd0, we_n}, 32'd1);
      chk("done_oe", {31'd0, oe_n}, 32'd1);
      @(posedge clk); #1;
      if (!hold) begin
         wr_en = 1'b0; rd_en = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      int          k;
      mem[2] = 16'h5678;
      mem[3] = 16'h1234;
      ref_words[1] = 32'h12345678;
      written_q.push_back(1);

      #1;
      chk("rst_rdata", read_data, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_we", {31'd0, we_n}, 32'd1);
      chk("rst_oe", {31'd0, oe_n}, 32'd1);
      chk("rst_addr", {14'd0, sram_addr}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle_chk();
      @(posedge clk); #1;

      do_txn(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 1'b0);
      do_txn(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0, 1'b0);
      do_txn(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 1'b0);
      do_txn(1'b1, 1'b0, 32'd5000, 32'hA5A53C3C, 1'b1, 1'b0);
      idle_chk();
      @(posedge clk); #1;
      do_txn(1'b0, 1'b1, 32'd5000, 32'd0, 1'b0, 1'b0);
      do_txn(1'b1, 1'b1, 32'd0, 32'h13579BDF, 1'b0, 1'b0);
      do_txn(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
      do_txn(1'b1, 1'b0, 32'd4096, 32'h0BADF00D, 1'b0, 1'b1);
      do_txn(1'b1, 1'b0, 32'hFFFFFFFC, 32'hCAFEBABE, 1'b0, 1'b0);
      idle_chk();
      @(posedge clk); #1;

      // Abort a read in HI1 after its low halfword has already been captured.
      rd_en = 1'b1; address = 32'd1028;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_rdata", read_data, 32'd0);
      chk("abort_we", {31'd0, we_n}, 32'd1);
      chk("abort_oe", {31'd0, oe_n}, 32'd1);
      chk("abort_addr", {14'd0, sram_addr}, 32'd0);
      rd_en = 1'b0;
      exp_rd = 32'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      idle_chk();
      @(posedge clk); #1;
      do_txn(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            a = $urandom;
            d = $urandom;
            do_txn(1'b1, $urandom_range(0, 1) == 1, a, d, 1'b0, i < 39 && $urandom_range(0, 3) == 0);
         end else begin
            k = written_q[$urandom_range(0, written_q.size() - 1)];
            a = 32'd1024 + 32'(k) * 32'd4 + ($urandom & 32'hFFF80003);
            do_txn(1'b0, 1'b1, a, 32'd0, $urandom_range(0, 3) == 0, i < 39 && $urandom_range(0, 3) == 0);
         end
      end
      idle_chk();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high. The ports SHALL be:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 wr_en  input  1  memory write request from the EXE/MEM pipeline register (mem_w_en).
REQ-005 rd_en  input  1  memory read request from the EXE/MEM pipeline register (mem_r_en).
REQ-006 address  input  32  byte address (ALU result).
REQ-007 write_data  input  32  store data (Rm value).
REQ-008 read_data  output  32  load data to the MEM/WB register.
REQ-009 ready  output  1  1 = transaction complete or none pending; the pipeline freeze is ~ready.
REQ-010 SRAM_DQ  inout  16  SRAM data bus.
REQ-011 SRAM_ADDR  output  18  SRAM halfword address.
REQ-012 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM strobes.

Function
REQ-013 The FSM SHALL have these states: IDLE, LO1, LO2, HI1, HI2, DONE.
REQ-014 Transitions SHALL be:
  - IDLE -> LO1 when rd_en|wr_en, else stay in IDLE.
  - LO1 -> LO2 -> HI1 -> HI2 -> DONE -> IDLE, unconditionally.
REQ-015 On leaving IDLE, the block SHALL latch the operation, address and write_data. Input changes during a transaction SHALL be ignored.
REQ-016 If wr_en and rd_en are both 1 in IDLE, the block SHALL perform a write.
REQ-017 ready SHALL be combinational and equal to 1 in DONE, 1 in IDLE with rd_en=wr_en=0, and 0 otherwise.
  - This gives 5 stall cycles per access: ready is 0 in the request cycle and in LO1..HI2, and 1 in DONE.
REQ-018 The word index SHALL be idx[16:0] = (address - 32'd1024)[18:2], computed with modulo-2^32 subtraction; other bits are ignored.
REQ-019 SRAM_ADDR SHALL be {idx,1'b0} in LO1/LO2, {idx,1'b1} in HI1/HI2, and 0 in IDLE/DONE.
REQ-020 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be tied to 0.
REQ-021 SRAM_WE_N SHALL be 0 only in LO1, LO2, HI1 and HI2 of a write, and 1 otherwise.
REQ-022 SRAM_OE_N SHALL be 0 only in LO1, LO2, HI1 and HI2 of a read, and 1 otherwise.
REQ-023 SRAM_DQ SHALL be driven with write_data[15:0] in LO1/LO2 and write_data[31:16] in HI1/HI2 of a write, and SHALL be high-Z in all other states and for reads.
REQ-024 For reads, read_data[15:0] SHALL capture SRAM_DQ at the clock edge leaving LO2, and read_data[31:16] SHALL capture SRAM_DQ at the edge leaving HI2.
REQ-025 read_data SHALL hold its value between reads and SHALL NOT change during writes.
REQ-026 Back-to-back requests SHALL be accepted only from IDLE, so a request present in DONE is started one cycle later (after DONE -> IDLE).

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, read_data=0, latched fields=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0 and SRAM_DQ high-Z.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction immediately, leaving no partial read_data update after the reset edge.
REQ-029 After reset deasserts, ready SHALL follow REQ-017 from IDLE.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Write: address=32'd1028, write_data=32'hDEADBEEF, wr_en held -> SRAM_ADDR=18'd2 with DQ=16'hBEEF for 2 cycles, then SRAM_ADDR=18'd3 with DQ=16'hDEAD for 2 cycles, WE_N low for 4 cycles; ready=0 for 5 cycles, then 1.
  - Read: SRAM model holds halfword 2=16'h5678 and 3=16'h1234, rd_en with address=1028 -> OE_N low for 4 cycles, DQ high-Z from the DUT, read_data=32'h12345678 in DONE, ready high in DONE.
  - Inputs changed after IDLE->LO1 (address=2048, write_data=0, wr_en=0) -> transaction completes with the original latched values.
  - wr_en=rd_en=1 -> write performed, read_data unchanged.
  - Continuous wr_en for two transactions -> DONE, IDLE, LO1 ...; ready is 1 only in the DONE cycles.
  - rst pulsed in HI1 of a read -> immediate IDLE, WE_N=OE_N=1, DQ high-Z, read_data=0; a following read completes normally.
